muldiv_ctrl: RTL and testbench

Iterative multiply/divide unit with its sequencing controller for the pipelined MIPS32 core. It sits beside the EX-stage ALU and owns the architectural HI/LO registers. It executes MULT/MULTU/DIV/DIVU over a fixed 33-cycle sequence and services MTHI/MTLO/MFHI/MFLO. It raises a pipeline stall whenever the ID/EX instruction needs the unit or HI/LO while an operation is in flight.

---
 rtl/mips_pkg.sv | 28 ++
 rtl/md_iter.sv | 55 +++++
 rtl/muldiv_ctrl.sv | 147 ++++++++++++++
 tb/tb_muldiv_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS32 multiply/divide unit: op codes, sequencer
// states, iteration count and a conditional two's-complement helper.
package mips_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_RUN  = 2'b01,
        MD_FIX  = 2'b10
    } md_state_e;

    localparam logic [4:0] MD_ITER_LAST = 5'd31;

    function automatic logic [31:0] md_cneg32(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

    function automatic logic [63:0] md_cneg64(input logic [63:0] v, input logic neg);
        return neg ? (~v + 64'd1) : v;
    endfunction

endpackage

// File: rtl/md_iter.sv
// One-bit-per-cycle datapath: 64-bit accumulator with shift-add (multiply)
// and restoring trial-subtract (divide).
module md_iter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_load,
    input  logic        i_step,
    input  logic        i_is_div,
    input  logic [31:0] i_init_lo,
    input  logic [31:0] i_opnd,
    output logic [63:0] o_acc
);

    logic [63:0] r_acc;
    logic [31:0] r_opnd;

    logic [32:0] w_sum;
    logic [32:0] w_shift;
    logic        w_ge;
    logic [31:0] w_rem_sub;
    logic [63:0] w_acc_next;

    // Low half starts as multiplier/dividend and is consumed as result bits shift in.
    always_comb begin
        w_sum      = {1'b0, r_acc[63:32]} + {1'b0, (r_acc[0] ? r_opnd : 32'd0)};
        w_shift    = r_acc[63:31];
        w_ge       = (w_shift >= {1'b0, r_opnd});
        w_rem_sub  = w_shift[31:0] - r_opnd;
        w_acc_next = r_acc;
        if (i_is_div) begin
            if (w_ge) begin
                w_acc_next = {w_rem_sub, r_acc[30:0], 1'b1};
            end else begin
                w_acc_next = {w_shift[31:0], r_acc[30:0], 1'b0};
            end
        end else begin
            w_acc_next = {w_sum, r_acc[31:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc  <= 64'd0;
            r_opnd <= 32'd0;
        end else if (i_load) begin
            r_acc  <= {32'd0, i_init_lo};
            r_opnd <= i_opnd;
        end else if (i_step) begin
            r_acc  <= w_acc_next;
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/muldiv_ctrl.sv
// MIPS32 multiply/divide sequencer: IDLE/RUN/FIX FSM, iteration counter,
// sign fix-up, architectural HI/LO and the ID/EX stall.
module muldiv_ctrl
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    input  logic             mf_req,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             stall,
    output logic             done
);

    md_state_e   r_state;
    md_state_e   w_state_next;
    logic [4:0]  r_count;
    logic        r_is_div;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_div0;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_load;
    logic        w_step;
    logic        w_fix;
    logic        w_op_signed;
    logic        w_op_div;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [63:0] w_acc;
    logic [63:0] w_prod;
    logic [31:0] w_quot;
    logic [31:0] w_rem;
    logic [31:0] w_fix_hi;
    logic [31:0] w_fix_lo;

    assign w_op_signed = (op == MD_MULT) || (op == MD_DIV);
    assign w_op_div    = (op == MD_DIV)  || (op == MD_DIVU);
    assign w_mag_a     = md_cneg32(src_a, w_op_signed & src_a[31]);
    assign w_mag_b     = md_cneg32(src_b, w_op_signed & src_b[31]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= MD_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_fix        = 1'b0;
        unique case (r_state)
            MD_IDLE: begin
                if (start) begin
                    w_load       = 1'b1;
                    w_state_next = MD_RUN;
                end
            end
            MD_RUN: begin
                w_step = 1'b1;
                if (r_count == 5'd0) begin
                    w_state_next = MD_FIX;
                end
            end
            MD_FIX: begin
                w_fix        = 1'b1;
                w_state_next = MD_IDLE;
            end
            default: w_state_next = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count  <= 5'd0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
        end else if (w_load) begin
            r_count  <= MD_ITER_LAST;
            r_is_div <= w_op_div;
            r_neg_q  <= w_op_signed & (src_a[31] ^ src_b[31]);
            r_neg_r  <= w_op_signed & src_a[31];
            r_div0   <= (src_b == '0);
        end else if (w_step && (r_count != 5'd0)) begin
            r_count  <= r_count - 5'd1;
        end
    end

    md_iter u_iter (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (w_load),
        .i_step    (w_step),
        .i_is_div  (r_is_div),
        .i_init_lo (w_op_div ? w_mag_a : w_mag_b),
        .i_opnd    (w_op_div ? w_mag_b : w_mag_a),
        .o_acc     (w_acc)
    );

    // Remainder follows the dividend sign; a zero divisor forces an all-ones quotient.
    assign w_prod   = md_cneg64(w_acc, r_neg_q);
    assign w_quot   = md_cneg32(w_acc[31:0], r_neg_q);
    assign w_rem    = md_cneg32(w_acc[63:32], r_neg_r);
    assign w_fix_hi = r_is_div ? w_rem : w_prod[63:32];
    assign w_fix_lo = r_is_div ? (r_div0 ? 32'hFFFF_FFFF : w_quot) : w_prod[31:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else if (w_fix) begin
            r_hi <= w_fix_hi;
            r_lo <= w_fix_lo;
        end else if ((r_state == MD_IDLE) && !start) begin
            if (mthi) begin
                r_hi <= wdata;
            end
            if (mtlo) begin
                r_lo <= wdata;
            end
        end
    end

    assign hi    = r_hi;
    assign lo    = r_lo;
    assign busy  = (r_state != MD_IDLE);
    assign done  = w_fix;
    assign stall = busy & (start | mf_req | mthi | mtlo);

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: directed ops push expected HI/LO,
// a monitor checks them when done pulses.
module tb_muldiv_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wdata;
    logic        mf_req;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        stall;
    logic        done;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    int   cyc    = 0;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    muldiv_ctrl #(.WIDTH(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .src_a  (src_a),
        .src_b  (src_b),
        .mthi   (mthi),
        .mtlo   (mtlo),
        .wdata  (wdata),
        .mf_req (mf_req),
        .hi     (hi),
        .lo     (lo),
        .busy   (busy),
        .stall  (stall),
        .done   (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pop on done, check latency, then HI/LO after the write edge.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && done === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_done: got done=1 expected no pending op");
            end else begin
                e = sb_q.pop_front();
                check({e.name, " latency"}, 64'(cyc - e.cyc), 64'd32);
                @(posedge clk);
                #1;
                check({e.name, " hi"}, {32'd0, hi}, {32'd0, e.hi});
                check({e.name, " lo"}, {32'd0, lo}, {32'd0, e.lo});
                $display("txn %-16s hi=%08h lo=%08h (exp %08h %08h)", e.name, hi, lo, e.hi, e.lo);
            end
        end
    end

    task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] hi_e, input logic [31:0] lo_e,
                            input string name, input bit push);
        @(negedge clk);
        op    = o;
        src_a = a;
        src_b = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (push) sb_q.push_back('{hi: hi_e, lo: lo_e, cyc: cyc, name: name});
    endtask

    task automatic wait_idle(input bit exp_stall, output int nb, output int nbad);
        nb   = 0;
        nbad = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (busy !== 1'b1) break;
            nb++;
            if (stall !== exp_stall) nbad++;
        end
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] hi_e, input logic [31:0] lo_e, input string name);
        int nb;
        int nbad;
        start_op(o, a, b, hi_e, lo_e, name, 1'b1);
        wait_idle(1'b0, nb, nbad);
        check({name, " busy_cycles"}, 64'(nb), 64'd33);
        check({name, " stall_idle"}, 64'(nbad), 64'd0);
    endtask

    initial begin
        int nb;
        int nbad;
        rst_n  = 1'b1;
        start  = 1'b0;
        op     = 2'b00;
        src_a  = 32'd0;
        src_b  = 32'd0;
        mthi   = 1'b0;
        mtlo   = 1'b0;
        wdata  = 32'd0;
        mf_req = 1'b0;

        #3 rst_n = 1'b0;
        #1;
        check("reset hi", {32'd0, hi}, 64'd0);
        check("reset lo", {32'd0, lo}, 64'd0);
        check("reset busy", {63'd0, busy}, 64'd0);
        check("reset done", {63'd0, done}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max");
        run_op(OP_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_m3x7");
        run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_m7d2");
        run_op(OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, "div_7dm2");
        run_op(OP_DIVU,  32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF, "divu_100d0");
        run_op(OP_DIV,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, "div_m5d0");
        run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "div_min_m1");
        run_op(OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, "mult_min_min");

        // MFHI/MFLO waiting on an in-flight MULTU must stall through FIX.
        start_op(OP_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, "multu_6x7", 1'b1);
        mf_req = 1'b1;
        wait_idle(1'b1, nb, nbad);
        check("mf busy_cycles", 64'(nb), 64'd33);
        check("mf stall_while_busy", 64'(nbad), 64'd0);
        check("mf stall_after", {63'd0, stall}, 64'd0);
        check("mf lo_visible", {32'd0, lo}, 64'd42);
        mf_req = 1'b0;

        // MTHI while idle, then both at once.
        mthi  = 1'b1;
        wdata = 32'h0000_1234;
        @(posedge clk);
        #1;
        check("mthi hi", {32'd0, hi}, 64'h1234);
        check("mthi lo_kept", {32'd0, lo}, 64'd42);
        @(negedge clk);
        mtlo  = 1'b1;
        wdata = 32'hA5A5_0F0F;
        @(posedge clk);
        #1;
        check("mthilo hi", {32'd0, hi}, 64'hA5A5_0F0F);
        check("mthilo lo", {32'd0, lo}, 64'hA5A5_0F0F);
        @(negedge clk);
        mthi = 1'b0;
        mtlo = 1'b0;

        // MTLO presented while busy: ignored, stalled, applied once idle.
        start_op(OP_MULTU, 32'd2, 32'd3, 32'd0, 32'd6, "multu_2x3", 1'b1);
        mtlo  = 1'b1;
        wdata = 32'h0000_0055;
        wait_idle(1'b1, nb, nbad);
        check("mtlo busy_stall", 64'(nbad), 64'd0);
        check("mtlo stall_after", {63'd0, stall}, 64'd0);
        @(posedge clk);
        #1;
        check("mtlo applied_lo", {32'd0, lo}, 64'h55);
        check("mtlo applied_hi", {32'd0, hi}, 64'd0);
        @(negedge clk);
        mtlo = 1'b0;

        // Reset pulsed mid-divide abandons the op.
        start_op(OP_DIV, 32'hFFFF_FF9C, 32'd7, 32'd0, 32'd0, "div_abort", 1'b0);
        repeat (9) @(negedge clk);
        check("abort busy_before", {63'd0, busy}, 64'd1);
        rst_n = 1'b0;
        #1;
        check("abort busy", {63'd0, busy}, 64'd0);
        check("abort hi", {32'd0, hi}, 64'd0);
        check("abort lo", {32'd0, lo}, 64'd0);
        check("abort done", {63'd0, done}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(OP_DIVU, 32'd9, 32'd4, 32'd1, 32'd2, "divu_9d4");

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
